// File: rtl/fifo_uart_tx.sv
// Drains a first-word-fall-through FIFO and serialises each word as an async
// frame: start bit, data LSB first, optional parity, then one or two stop bits.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_val,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read,
  output logic                  txd,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            state_reg;
  logic [CW-1:0]         cnt_reg;
  logic [IW-1:0]         idx_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  parity_reg;
  logic                  txd_reg;
  logic                  busy_reg;
  logic                  read_reg;
  logic                  done_reg;

  logic cnt_done;
  logic frame_end;
  logic capture;

  // idx_reg doubles as the stop-bit counter once the data bits are out.
  assign cnt_done  = (cnt_reg == CNT_LAST);
  assign frame_end = (state_reg == S_STOP) && cnt_done && (idx_reg == STOP_LAST);
  // The end-of-frame edge may capture the next word so frames run gap-free.
  assign capture   = enable && fifo_val && ((state_reg == S_IDLE) || frame_end);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      data_reg   <= '0;
      parity_reg <= 1'b0;
      txd_reg    <= 1'b1;
      busy_reg   <= 1'b0;
      read_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      read_reg <= capture;
      done_reg <= frame_end;
      if (capture) begin
        data_reg   <= fifo_data;
        parity_reg <= (^fifo_data) ^ ODD_PAR;
        txd_reg    <= 1'b0;
        busy_reg   <= 1'b1;
        state_reg  <= S_START;
        cnt_reg    <= '0;
        idx_reg    <= '0;
      end else if (frame_end) begin
        txd_reg   <= 1'b1;
        busy_reg  <= 1'b0;
        state_reg <= S_IDLE;
        cnt_reg   <= '0;
        idx_reg   <= '0;
      end else if (state_reg != S_IDLE) begin
        cnt_reg <= cnt_done ? '0 : cnt_reg + 1'b1;
        if (cnt_done) begin
          case (state_reg)
            S_START: begin
              state_reg <= S_DATA;
              txd_reg   <= data_reg[0];
            end
            S_DATA: begin
              if (idx_reg == DATA_LAST) begin
                idx_reg <= '0;
                if (PARITY != 0) begin
                  state_reg <= S_PARITY;
                  txd_reg   <= parity_reg;
                end else begin
                  state_reg <= S_STOP;
                  txd_reg   <= 1'b1;
                end
              end else begin
                idx_reg  <= idx_reg + 1'b1;
                data_reg <= data_reg >> 1;
                txd_reg  <= data_reg[1];
              end
            end
            S_PARITY: begin
              state_reg <= S_STOP;
              txd_reg   <= 1'b1;
            end
            S_STOP: idx_reg <= idx_reg + 1'b1;
            default: state_reg <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign fifo_read  = read_reg;
  assign txd        = txd_reg;
  assign busy       = busy_reg;
  assign frame_done = done_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed checks of fifo_uart_tx: frame shape, back-to-back drain, parity,
// enable gating, asynchronous reset and a loopback through a bench receiver.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       fifo_val;
  logic [7:0] fifo_data;
  logic       fifo_read, txd, busy, frame_done;

  logic       en_p, val_p;
  logic [7:0] data_p;
  logic       read_e, txd_e, busy_e, done_e;
  logic       read_o, txd_o, busy_o, done_o;

  int errors = 0;
  int checks = 0;

  // First-word-fall-through FIFO model feeding the default-parameter DUT.
  logic [7:0] fifo_mem [0:63];
  logic [5:0] wr_ptr = '0;
  logic [5:0] rd_ptr = '0;
  assign fifo_val  = (wr_ptr != rd_ptr);
  assign fifo_data = fifo_mem[rd_ptr];

  always @(posedge clk) begin
    if (fifo_read && fifo_val) rd_ptr <= rd_ptr + 6'd1;
  end

  always #5 clk = ~clk;

  fifo_uart_tx dut (
    .clk(clk), .reset(rst), .enable(enable), .fifo_val(fifo_val),
    .fifo_data(fifo_data), .fifo_read(fifo_read), .txd(txd),
    .busy(busy), .frame_done(frame_done)
  );

  fifo_uart_tx #(.PARITY(1)) dut_even (
    .clk(clk), .reset(rst), .enable(en_p), .fifo_val(val_p),
    .fifo_data(data_p), .fifo_read(read_e), .txd(txd_e),
    .busy(busy_e), .frame_done(done_e)
  );

  fifo_uart_tx #(.PARITY(2)) dut_odd (
    .clk(clk), .reset(rst), .enable(en_p), .fifo_val(val_p),
    .fifo_data(data_p), .fifo_read(read_o), .txd(txd_o),
    .busy(busy_o), .frame_done(done_o)
  );

  typedef struct {
    logic [7:0] word;
    logic [9:0] frame;  // line level per bit period, index 0 = start bit
  } vec_t;

  vec_t       vecs [0:3];
  logic [9:0] exp_frames [0:2];
  logic [7:0] sent_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic wait_capture();
    int t = 0;
    while (busy !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("capture", busy, 1);
  endtask

  // Entered on the first negedge after a capture edge (frame cycle k=0).
  task automatic watch_frames(input int n, input int drop_at);
    for (int k = 0; k < n * 40; k++) begin
      if (k == drop_at) enable = 1'b0;
      chk("txd_level", txd, exp_frames[k / 40][(k % 40) / 4]);
      chk("busy_in_frame", busy, 1);
      chk("fifo_read", fifo_read, (k % 40) == 0);
      chk("frame_done", frame_done, (k % 40) == 0 && k > 0);
      if ((k % 40) == 39)
        $display("frame %0d expected levels %b ended at %0t", k / 40, exp_frames[k / 40], $time);
      @(negedge clk);
    end
    chk("done_pulse", frame_done, 1);
    chk("busy_after", busy, 0);
    chk("txd_idle", txd, 1);
    @(negedge clk);
    chk("done_single", frame_done, 0);
  endtask

  initial begin
    logic [7:0] rx;
    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h80, 10'b1100000000};
    vecs[2] = '{8'h00, 10'b1000000000};
    vecs[3] = '{8'h6E, 10'b1011011100};

    rst = 1'b1; enable = 1'b0; en_p = 1'b0; val_p = 1'b0; data_p = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_txd", txd, 1);
    chk("reset_busy", busy, 0);
    chk("reset_read", fifo_read, 0);
    chk("reset_done", frame_done, 0);
    chk("reset_txd_even", txd_e, 1);
    rst = 1'b0;
    enable = 1'b1;

    // Single frames from the vector table
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      push(vecs[i].word);
      exp_frames[0] = vecs[i].frame;
      wait_capture();
      watch_frames(1, -1);
    end

    // Three words queued: gap-free frames, reads 40 cycles apart
    @(negedge clk);
    push(8'h01); push(8'hFF); push(8'h3C);
    exp_frames[0] = 10'b1000000010;
    exp_frames[1] = 10'b1111111110;
    exp_frames[2] = 10'b1001111000;
    wait_capture();
    watch_frames(3, -1);
    chk("fifo_empty", fifo_val, 0);

    // Enable gating with data waiting
    @(negedge clk);
    enable = 1'b0;
    push(8'hC3); push(8'h5A);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("gated_idle", {txd, fifo_read, busy}, 3'b100);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("capture_next_edge", busy, 1);
    exp_frames[0] = 10'b1110000110;
    watch_frames(1, 10);
    chk("word_left", fifo_val, 1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("no_second_pop", {fifo_read, busy}, 2'b00);
    end

    // Reset at cycle 15 of a frame carrying 0x5A
    enable = 1'b1;
    @(negedge clk);
    chk("capture_5a", busy, 1);
    repeat (15) @(negedge clk);
    chk("pre_reset_txd", txd, 0);
    #1 rst = 1'b1;
    #1;
    chk("reset_async_txd", txd, 1);
    chk("reset_async_busy", busy, 0);
    push(8'h96);
    @(negedge clk);
    rst = 1'b0;
    exp_frames[0] = 10'b1100101100;
    wait_capture();
    watch_frames(1, -1);

    // Parity: 0x07 on even and odd instances, data changed mid-frame
    @(negedge clk);
    data_p = 8'h07; val_p = 1'b1; en_p = 1'b1;
    @(negedge clk);
    val_p = 1'b0; en_p = 1'b0;
    for (int k = 0; k <= 45; k++) begin
      if (k == 0) begin
        chk("par_read", read_e, 1);
        chk("par_busy", {busy_e, busy_o}, 2'b11);
      end
      if (k == 5) data_p = 8'hFF;
      if (k == 6) chk("par_bit0", {txd_e, txd_o}, 2'b11);
      if (k == 18) chk("par_bit3", {txd_e, txd_o}, 2'b00);
      if (k == 38) begin
        chk("parity_even", txd_e, 1);
        chk("parity_odd", txd_o, 0);
      end
      if (k == 41) chk("par_stop", {txd_e, txd_o}, 2'b11);
      if (k == 43) chk("par_len_busy", {busy_e, busy_o, done_e, done_o}, 4'b1100);
      if (k == 44) chk("par_len_done", {busy_e, busy_o, done_e, done_o}, 4'b0011);
      @(negedge clk);
    end
    $display("parity frames even=%b odd=%b at %0t", txd_e, txd_o, $time);

    // Loopback: random writes, receiver samples mid-bit
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int t = 0;
          logic [7:0] w;
          repeat ($urandom_range(0, 60)) @(negedge clk);
          while (6'(wr_ptr - rd_ptr) >= 6'd16 && t < 5000) begin
            @(negedge clk);
            t++;
          end
          w = 8'($urandom_range(0, 255));
          sent_q.push_back(w);
          push(w);
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          int t = 0;
          while (txd !== 1'b0 && t < 5000) begin
            @(negedge clk);
            t++;
          end
          chk("rx_start_seen", txd, 0);
          if (txd !== 1'b0) break;
          repeat (2) @(negedge clk);
          chk("rx_start", txd, 0);
          for (int j = 0; j < 8; j++) begin
            repeat (4) @(negedge clk);
            rx[j] = txd;
          end
          repeat (4) @(negedge clk);
          chk("rx_stop", txd, 1);
          if (sent_q.size() > 0) begin
            chk("rx_byte", rx, sent_q.pop_front());
          end else begin
            chk("rx_extra_byte", sent_q.size(), 1);
          end
          $display("rx byte %0d = %02h at %0t", n, rx, $time);
        end
      end
    join
    repeat (20) @(negedge clk);
    chk("loop_idle", {busy, fifo_val}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Drain-side consumer for the team's FIFOs (`fifo` / `ring_fifo`).
- Pops words through the FIFO's val/read interface and serialises each word onto a single line as an asynchronous serial frame: start bit, data LSB-first, optional parity, stop bits.
- Sits between a `ring_fifo` output and a chip pin or link; the FIFO absorbs bursts and this block drains at line rate.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; equals the upstream FIFO DATA_WIDTH.
- CLKS_PER_BIT, 4, clk cycles per serial bit; legal range ≥2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  permits fetching new words; sampled only at frame boundaries.
- fifo_val  in  1  upstream FIFO `val`; fifo_data is valid when high (first-word-fall-through).
- fifo_data  in  DATA_WIDTH  upstream FIFO `dataout`.
- fifo_read  out  1  upstream FIFO `read`; one-cycle pop pulse, registered.
- txd  out  1  serial line; idle level 1.
- busy  out  1  high while a frame is on the line.
- frame_done  out  1  one-cycle pulse on the cycle after the last stop-bit period ends.

Behaviour:
- Reset (async, immediate): txd=1, fifo_read=0, busy=0, frame_done=0, state=IDLE, counters cleared.
- FIFO contract:
  - The FIFO pops on a rising edge where read=1 and val=1.
  - This block never drives fifo_read high on two consecutive cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE, edge with enable=1 and fifo_val=1 (capture edge):
  - shift register <= fifo_data; fifo_read <= 1 for exactly one cycle.
  - txd <= 0; busy <= 1; state <= START.
  - The FIFO pops the captured word on the following edge.
- START: txd=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles.
  - Bit index counter is $clog2(DATA_WIDTH) bits wide.
  - Then PARITY if PARITY≠0, else STOP.
- PARITY:
  - Bit value is XOR of the captured word (even) or its inverse (odd).
  - Held CLKS_PER_BIT cycles, then STOP.
- STOP: txd=1 for STOP_BITS×CLKS_PER_BIT cycles.
- End of frame, at the edge ending the last stop-bit period:
  - frame_done <= 1 for one cycle.
  - If enable=1 and fifo_val=1, this edge is also a capture edge for the next word: no idle gap, busy stays 1.
  - Otherwise busy <= 0 and state <= IDLE.
- Frame length: L = CLKS_PER_BIT × (1 + DATA_WIDTH + (PARITY≠0) + STOP_BITS) cycles, measured from capture edge to end-of-frame edge. Defaults give L = 40.
- Bit-period counter:
  - $clog2(CLKS_PER_BIT) bits wide; counts 0..CLKS_PER_BIT-1 and wraps.
  - No off-by-one: each bit is exactly CLKS_PER_BIT cycles.
- enable deasserted mid-frame: current frame completes unchanged; no further capture.
- fifo_val dropping mid-frame: no effect; the word was latched at capture.
- fifo_data changing mid-frame: ignored; serialisation uses the latched copy only.
- Reset mid-frame: txd returns to 1 asynchronously. The in-flight word is discarded (already popped). After reset release, the next capture requires IDLE conditions.
- txd is driven from a flop; glitch-free.

Test Plan:
- Single word, defaults:
  - Stimulus: FIFO holds 0xA5, enable=1.
  - Required: one fifo_read pulse, the cycle after capture.
  - Required txd levels, each held 4 cycles: 0,1,0,1,0,0,1,0,1,1.
  - Required: frame_done at capture+40; busy high for exactly 40 cycles.
- Back-to-back:
  - Stimulus: FIFO holds 0x01, 0xFF, 0x3C.
  - Required: three frames with no idle cycle between them.
  - Required: fifo_read pulses exactly 40 cycles apart; never two consecutive read cycles.
  - Required: FIFO empty (val=0) after the third pop.
- Parity:
  - PARITY=1 with word 0x07 -> parity bit 1.
  - PARITY=2 with word 0x07 -> parity bit 0.
  - Frame length is 44 cycles in both cases.
- Enable gating:
  - Stimulus: fifo_val=1, enable=0 for 100 cycles.
  - Required: txd=1, fifo_read=0, busy=0 throughout.
  - Stimulus: set enable=1.
  - Required: capture on the next edge.
  - Stimulus: drop enable mid-frame.
  - Required: frame completes and no second pop occurs.
- Reset mid-frame:
  - Stimulus: assert reset at cycle 15 of a frame.
  - Required: txd=1 and busy=0 within the same cycle, before the next clk edge.
  - Stimulus: release reset with val=1.
  - Required: new capture of the next FIFO word.
- Random loopback:
  - Stimulus: `ring_fifo` (DEPTH=16) feeding this block; random writes; a bench receiver model sampling txd mid-bit.
  - Required: decoded byte stream equals the written stream, in order, with no loss or duplication over 100k cycles.
